button_conditioner: RTL and testbench

Multi-channel push-button front end. It is the parametrised successor to the per-button debounce/onepulse/extending_signal chain. Each channel synchronises a raw board input, debounces it with a programmable stability counter, and produces:
- a clean level,
- press and release pulses,
- a stretched press,
- an optional auto-repeat pulse train.

It sits between board pins (rst, clear_data, send_data, ...) and the control logic in top.

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/btn_cond_channel.sv | 146 ++++++++++++++
 rtl/button_conditioner.sv | 53 +++++
 tb/tb_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the button conditioner.
//   rpt_state_e : per-channel auto-repeat state
//   cnt_width   : bits needed to hold 0..max_val (never less than 1)
//   max_int     : larger of two integers, used when sizing shared timers
package btn_cond_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_cond_channel.sv
// One push-button channel: two-flop synchroniser, stability-counter debounce,
// registered press/release edges, stretched press and auto-repeat pulse train.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_i        raw asynchronous button input
//   repeat_en_i  auto-repeat enable
//   level_o      debounced level
//   press_o      1-cycle pulse in the first cycle level_o is 1
//   release_o    1-cycle pulse in the first cycle level_o is 0 after being 1
//   extended_o   press stretched to EXTEND_CYCLES cycles
//   repeat_o     press pulse plus auto-repeat pulses while held
//
// Auto-repeat FSM:
//   state  | meaning
//   IDLE   | no repeat pending; repeat_o mirrors press
//   DELAY  | held since press, counting down to the first auto pulse
//   REPEAT | held, emitting a pulse every REPEAT_PERIOD cycles
module btn_cond_channel
   import btn_cond_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int EXTEND_CYCLES = 4,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic extended_o,
   output logic repeat_o
);

   localparam int CNT_W = cnt_width(STABLE_CYCLES);
   localparam int EXT_W = cnt_width(EXTEND_CYCLES);
   localparam int TMR_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [EXT_W-1:0] EXT_LOAD    = EXT_W'(EXTEND_CYCLES - 1);
   localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [EXT_W-1:0] ecnt_q, ecnt_d;
   rpt_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             rpt_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         ecnt_q    <= '0;
         state_q   <= IDLE;
         tmr_q     <= '0;
      end else begin
         s1_q      <= btn_i;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         ecnt_q    <= ecnt_d;
         state_q   <= state_d;
         tmr_q     <= tmr_d;
      end
   end

   // Edge pulses are registered alongside the level flip so they line up
   // with the first cycle the new level is visible.
   always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         level_d   = s2_q;
         press_d   = s2_q;
         release_d = ~s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter is loaded the cycle after press; the press cycle itself is
   // covered by OR-ing press_q into the output.
   always_comb begin
      ecnt_d = ecnt_q;
      if (press_q) begin
         ecnt_d = EXT_LOAD;
      end else if (ecnt_q != '0) begin
         ecnt_d = ecnt_q - 1'b1;
      end
   end

   // Release or enable drop wins over a timer expiry in the same cycle.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      rpt_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            rpt_pulse = press_q;
            if (press_q && repeat_en_i) begin
               tmr_d   = DELAY_LOAD;
               state_d = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (!level_q || !repeat_en_i) begin
               state_d = IDLE;
            end else if (tmr_q == '0) begin
               rpt_pulse = 1'b1;
               tmr_d     = PERIOD_LOAD;
               state_d   = REPEAT;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign level_o    = level_q;
   assign press_o    = press_q;
   assign release_o  = release_q;
   assign extended_o = press_q | (ecnt_q != '0);
   assign repeat_o   = rpt_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: N_CH independent conditioning
// channels between board pins and the control logic.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_in_i     raw asynchronous button inputs
//   repeat_en_i  per-channel auto-repeat enable
//   level_o      debounced levels
//   press_o      press pulses
//   release_o    release pulses
//   extended_o   stretched press pulses
//   repeat_o     press plus auto-repeat pulses
module button_conditioner
   import btn_cond_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 16,
   parameter int EXTEND_CYCLES = 4,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in_i,
   input  logic [N_CH-1:0] repeat_en_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
   output logic [N_CH-1:0] extended_o,
   output logic [N_CH-1:0] repeat_o
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_cond_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .EXTEND_CYCLES (EXTEND_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .btn_i       (btn_in_i[i]),
         .repeat_en_i (repeat_en_i[i]),
         .level_o     (level_o[i]),
         .press_o     (press_o[i]),
         .release_o   (release_o[i]),
         .extended_o  (extended_o[i]),
         .repeat_o    (repeat_o[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

   localparam int N = 2;
   localparam int S = 4;
   localparam int E = 3;
   localparam int D = 10;
   localparam int P = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] btn_in = '0, repeat_en = '0;
   logic [N-1:0] level, press, rel, ext, rpt;

   // second instance with minimum timing parameters
   logic [0:0] b_btn = '0, b_en = '0;
   logic [0:0] b_level, b_press, b_rel, b_ext, b_rpt;

   logic [N-1:0] nxt_btn = '0, nxt_en = '0;
   logic         nxt_rst = 1'b1;
   logic [0:0]   nxt_bbtn = '0, nxt_ben = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   button_conditioner #(.N_CH(N), .STABLE_CYCLES(S), .EXTEND_CYCLES(E),
                        .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
      .clk(clk), .rst(rst), .btn_in_i(btn_in), .repeat_en_i(repeat_en),
      .level_o(level), .press_o(press), .release_o(rel),
      .extended_o(ext), .repeat_o(rpt));

   button_conditioner #(.N_CH(1), .STABLE_CYCLES(1), .EXTEND_CYCLES(3),
                        .REPEAT_DELAY(2), .REPEAT_PERIOD(1)) dut_b (
      .clk(clk), .rst(rst), .btn_in_i(b_btn), .repeat_en_i(b_en),
      .level_o(b_level), .press_o(b_press), .release_o(b_rel),
      .extended_o(b_ext), .repeat_o(b_rpt));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running exp finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Level flips once the synchronised input has disagreed with it for the
   // last S edges. The synchronised value seen at an edge is the raw sample
   // taken two edges earlier, so a window of S+2 raw samples is kept.
   bit m_smp [N][S+2];
   bit m_lvl [N];
   bit m_prs [N];
   bit m_rel [N];
   int m_last[N];
   bit m_ok  [N];   // enable and level held every cycle since last press

   initial begin
      for (int ch = 0; ch < N; ch++) begin
         m_last[ch] = -1000;
         m_ok[ch]   = 1'b0;
      end
   end

   task automatic model_edge();
      cyc++;
      for (int ch = 0; ch < N; ch++) begin
         if (rst) begin
            for (int k = 0; k < S + 2; k++) m_smp[ch][k] = 1'b0;
            m_lvl[ch]  = 1'b0;
            m_prs[ch]  = 1'b0;
            m_rel[ch]  = 1'b0;
            m_last[ch] = -1000;
            m_ok[ch]   = 1'b0;
         end else begin
            bit flip;
            m_ok[ch] = m_ok[ch] && repeat_en[ch] && m_lvl[ch];
            for (int k = 0; k < S + 1; k++) m_smp[ch][k] = m_smp[ch][k+1];
            m_smp[ch][S+1] = btn_in[ch];
            flip = 1'b1;
            for (int k = 0; k < S; k++)
               if (m_smp[ch][k] == m_lvl[ch]) flip = 1'b0;
            m_prs[ch] = flip && !m_lvl[ch];
            m_rel[ch] = flip && m_lvl[ch];
            if (flip) m_lvl[ch] = !m_lvl[ch];
            if (m_prs[ch]) begin
               m_last[ch] = cyc;
               m_ok[ch]   = 1'b1;
            end
         end
      end
   endtask

   task automatic model_check();
      logic [N-1:0] e_l, e_p, e_r, e_x, e_t;
      for (int ch = 0; ch < N; ch++) begin
         int d;
         d = cyc - m_last[ch];
         e_l[ch] = m_lvl[ch];
         e_p[ch] = m_prs[ch];
         e_r[ch] = m_rel[ch];
         e_x[ch] = (d >= 0) && (d < E);
         e_t[ch] = m_prs[ch] ||
                   (m_ok[ch] && repeat_en[ch] && m_lvl[ch] && d >= D && ((d - D) % P) == 0);
      end
      chk("model_level", level, e_l);
      chk("model_press", press, e_p);
      chk("model_release", rel, e_r);
      chk("model_extended", ext, e_x);
      chk("model_repeat", rpt, e_t);
   endtask

   // One clock cycle: model and DUT take the edge, the next inputs are
   // applied just after it, outputs are sampled on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      btn_in    = nxt_btn;
      repeat_en = nxt_en;
      rst       = nxt_rst;
      b_btn     = nxt_bbtn;
      b_en      = nxt_ben;
      @(negedge clk);
      model_check();
   endtask

   // ---------------- directed vector tables ----------------
   typedef struct {
      logic [N-1:0] btn;
      logic [N-1:0] en;
      logic         r;
      logic [N-1:0] lv, pr, rl, ex, rp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [N-1:0] b, input logic [N-1:0] e, input logic r,
                               input logic [N-1:0] lv, input logic [N-1:0] pr,
                               input logic [N-1:0] rl, input logic [N-1:0] ex,
                               input logic [N-1:0] rp);
      vec_t v;
      v.btn = b; v.en = e; v.r = r;
      v.lv = lv; v.pr = pr; v.rl = rl; v.ex = ex; v.rp = rp;
      tbl.push_back(v);
   endfunction

   task automatic run_table(input string nm);
      foreach (tbl[i]) begin
         nxt_btn = tbl[i].btn;
         nxt_en  = tbl[i].en;
         nxt_rst = tbl[i].r;
         cycle();
         chk({nm, "_level"},    level, tbl[i].lv);
         chk({nm, "_press"},    press, tbl[i].pr);
         chk({nm, "_release"},  rel,   tbl[i].rl);
         chk({nm, "_extended"}, ext,   tbl[i].ex);
         chk({nm, "_repeat"},   rpt,   tbl[i].rp);
      end
      tbl.delete();
   endtask

   function automatic logic b2(input bit x);
      return x;
   endfunction

   initial begin
      int rate;
      // reset: outputs zero while and after reset, button activity ignored
      for (int c = 0; c < 3; c++) add(2'b11, 2'b11, 1'b1, '0, '0, '0, '0, '0);
      for (int c = 0; c < 8; c++) add(2'b00, 2'b00, 1'b0, '0, '0, '0, '0, '0);
      run_table("reset");

      // clean press then release on ch0, no repeat
      for (int c = 0; c < 32; c++)
         add({1'b0, b2(c < 20)}, 2'b00, 1'b0,
             {1'b0, b2(c >= 6 && c < 26)}, {1'b0, b2(c == 6)}, {1'b0, b2(c == 26)},
             {1'b0, b2(c >= 6 && c <= 8)}, {1'b0, b2(c == 6)});
      run_table("press_release");

      // 3-cycle glitch is swallowed
      for (int c = 0; c < 12; c++)
         add({1'b0, b2(c < 3)}, 2'b00, 1'b0, '0, '0, '0, '0, '0);
      run_table("glitch");

      // bounce then stable high from cycle 10, release from cycle 25
      for (int c = 0; c < 37; c++)
         add({1'b0, b2(c < 25 && (c >= 10 || ((c / 2) % 2) == 1))}, 2'b00, 1'b0,
             {1'b0, b2(c >= 16 && c < 31)}, {1'b0, b2(c == 16)}, {1'b0, b2(c == 31)},
             {1'b0, b2(c >= 16 && c <= 18)}, {1'b0, b2(c == 16)});
      run_table("bounce");

      // auto-repeat on ch0 while ch1 runs an independent press/release
      for (int c = 0; c < 41; c++)
         add({b2(c >= 3 && c < 30), b2(c < 28)}, 2'b01, 1'b0,
             {b2(c >= 9 && c < 36), b2(c >= 6 && c < 34)},
             {b2(c == 9), b2(c == 6)},
             {b2(c == 36), b2(c == 34)},
             {b2(c >= 9 && c <= 11), b2(c >= 6 && c <= 8)},
             {b2(c == 9), b2(c == 6 || c == 16 || c == 21 || c == 26 || c == 31)});
      run_table("autorepeat");

      // enable dropped at cycle 18 stops the train
      for (int c = 0; c < 36; c++)
         add({1'b0, b2(c < 25)}, {1'b0, b2(c < 18)}, 1'b0,
             {1'b0, b2(c >= 6 && c < 31)}, {1'b0, b2(c == 6)}, {1'b0, b2(c == 31)},
             {1'b0, b2(c >= 6 && c <= 8)}, {1'b0, b2(c == 6 || c == 16)});
      run_table("repeat_en_drop");

      // minimum-parameter instance: presses 2 cycles apart retrigger extend,
      // release in DELAY cancels the pending pulse
      for (int c = 0; c < 12; c++) begin
         nxt_bbtn = (c != 1);
         nxt_ben  = 1'b1;
         cycle();
         chk("retrig_level",    {1'b0, b_level}, {1'b0, b2(c == 3 || c >= 5)});
         chk("retrig_press",    {1'b0, b_press}, {1'b0, b2(c == 3 || c == 5)});
         chk("retrig_release",  {1'b0, b_rel},   {1'b0, b2(c == 4)});
         chk("retrig_extended", {1'b0, b_ext},   {1'b0, b2(c >= 3 && c <= 7)});
         chk("retrig_repeat",   {1'b0, b_rpt},   {1'b0, b2(c == 3 || c == 5 || c >= 7)});
      end
      nxt_bbtn = 1'b0;
      nxt_ben  = 1'b0;
      for (int c = 0; c < 4; c++) cycle();

      // reset while held in REPEAT: fresh press, no release, repeat restarts
      for (int c = 0; c < 46; c++)
         add(2'b01, 2'b01, b2(c == 20),
             {1'b0, b2((c >= 6 && c <= 20) || c >= 27)},
             {1'b0, b2(c == 6 || c == 27)}, 2'b00,
             {1'b0, b2((c >= 6 && c <= 8) || (c >= 27 && c <= 29))},
             {1'b0, b2(c == 6 || c == 16 || c == 27 || c == 37 || c == 42)});
      run_table("reset_hold");

      // randomized traffic against the model
      rate = 8;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rate = 3;
               1:       rate = 8;
               default: rate = 40;
            endcase
         end
         for (int ch = 0; ch < N; ch++)
            if ($urandom_range(0, rate - 1) == 0) nxt_btn[ch] = ~nxt_btn[ch];
         for (int ch = 0; ch < N; ch++)
            if ($urandom_range(0, 29) == 0) nxt_en[ch] = ~nxt_en[ch];
         nxt_rst = ($urandom_range(0, 399) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
